// File: rtl/acc_result_collector.sv
// Collects accumulator results into a first-word-fall-through FIFO tagged with a
// neuron index, and tracks the per-frame argmax plus sticky protocol/overflow flags.
module acc_result_collector #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NUM_NEURONS = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         acc_sel,
    input  logic                         acc_en,
    input  logic [DATA_W-1:0]            acc_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [3:0]                   out_idx,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [3:0]                   best_idx,
    output logic                         best_valid,
    output logic                         overflow,
    output logic                         proto_err,
    input  logic                         clr_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic [DATA_W-1:0]        data_mem [DEPTH];
    logic [IDX_W-1:0]         idx_mem  [DEPTH];

    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     full_q, full_d;
    logic                     empty_q, empty_d;
    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
    logic                     arm_q, arm_d;
    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_cand_q, best_cand_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic                     best_valid_q, best_valid_d;
    logic                     overflow_q, overflow_d;
    logic                     proto_err_q, proto_err_d;

    logic                     pop_c;
    logic                     push_c;
    logic                     take_c;

    // FIFO pointers, occupancy and frame index bookkeeping
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_idx_d = wr_idx_q;

        pop_c  = out_ready && !empty_q;
        push_c = acc_en && (!full_q || pop_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            wr_idx_d = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Running argmax within the frame; winner published when the last neuron lands
    always_comb begin
        best_val_d   = best_val_q;
        best_cand_d  = best_cand_q;
        best_idx_d   = best_idx_q;
        best_valid_d = 1'b0;

        take_c = (wr_idx_q == '0) || ($signed(acc_data) > best_val_q);

        if (push_c) begin
            if (take_c) begin
                best_val_d  = $signed(acc_data);
                best_cand_d = wr_idx_q;
            end
            if (wr_idx_q == LAST_IDX) begin
                best_idx_d   = take_c ? wr_idx_q : best_cand_q;
                best_valid_d = 1'b1;
            end
        end
    end

    // Group-start arming and sticky error flags; a same-cycle set beats clr_err
    always_comb begin
        arm_d       = arm_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;

        if (acc_en) begin
            arm_d = 1'b0;
        end else if (acc_sel) begin
            arm_d = 1'b1;
        end

        if (acc_en && full_q && !pop_c) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end

        if (acc_en && !arm_q && !acc_sel) begin
            proto_err_d = 1'b1;
        end else if (clr_err) begin
            proto_err_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            wr_idx_q     <= '0;
            arm_q        <= 1'b0;
            best_val_q   <= '0;
            best_cand_q  <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            wr_idx_q     <= wr_idx_d;
            arm_q        <= arm_d;
            best_val_q   <= best_val_d;
            best_cand_q  <= best_cand_d;
            best_idx_q   <= best_idx_d;
            best_valid_q <= best_valid_d;
            overflow_q   <= overflow_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // FIFO storage; contents are only visible through the empty-gated read mux
    always_ff @(posedge clk) begin
        if (push_c) begin
            data_mem[wr_ptr_q] <= acc_data;
            idx_mem[wr_ptr_q]  <= wr_idx_q;
        end
    end

    assign out_valid  = !empty_q;
    assign out_data   = empty_q ? '0 : data_mem[rd_ptr_q];
    assign out_idx    = empty_q ? '0 : idx_mem[rd_ptr_q];
    assign out_last   = (out_idx == LAST_IDX);
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign best_idx   = best_idx_q;
    assign best_valid = best_valid_q;
    assign overflow   = overflow_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_acc_result_collector.sv
// Bench for acc_result_collector: expected FIFO entries go into a queue as stimulus
// is issued; a monitor pops and compares each entry as the DUT hands it off.
module tb_acc_result_collector;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NN     = 10;
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              reset;
    logic              acc_sel;
    logic              acc_en;
    logic [DATA_W-1:0] acc_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_idx;
    logic              out_last;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [3:0]        best_idx;
    logic              best_valid;
    logic              overflow;
    logic              proto_err;
    logic              clr_err;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [3:0]        i;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] nxt_idx;
    int         total;
    int         bad;

    acc_result_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_NEURONS(NN)
    ) dut (
        .clk(clk), .reset(reset), .acc_sel(acc_sel), .acc_en(acc_en),
        .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .count(count), .full(full), .empty(empty), .best_idx(best_idx),
        .best_valid(best_valid), .overflow(overflow), .proto_err(proto_err),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d);
        exp_t e;
        e.d = d;
        e.i = nxt_idx;
        exp_q.push_back(e);
        nxt_idx = (nxt_idx == 4'(NN - 1)) ? 4'd0 : nxt_idx + 4'd1;
    endtask

    // One sel/en group: strobe acc_sel, then acc_en with data on the next edge
    task automatic grp(input logic [DATA_W-1:0] d, input bit accepted);
        acc_sel = 1'b1;
        cyc();
        acc_sel  = 1'b0;
        acc_en   = 1'b1;
        acc_data = d;
        if (accepted) push_exp(d);
        cyc();
        acc_en = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        nxt_idx = 4'd0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
    endtask

    // Scoreboard monitor: a handoff happens on the edge after a negedge with valid&ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected actual=idx%0h/%0h required=none", out_idx, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_idx", 32'(out_idx), 32'(e.i));
                    chk("sb_last", 32'(out_last), 32'(e.i == 4'(NN - 1)));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int vals [10] = '{5, -3, 9, 9, 0, 2, -8, 1, 7, 4};

    initial begin
        total     = 0;
        bad       = 0;
        nxt_idx   = 4'd0;
        reset     = 1'b1;
        acc_sel   = 1'b0;
        acc_en    = 1'b0;
        acc_data  = '0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        #2;
        reset = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_best_valid", 32'(best_valid), 32'd0);
        chk("rst_best_idx", 32'(best_idx), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Single capture with two idle cycles between sel and en
        acc_sel = 1'b1;
        cyc();
        acc_sel = 1'b0;
        cyc();
        cyc();
        acc_en   = 1'b1;
        acc_data = 16'h0123;
        push_exp(16'h0123);
        cyc();
        acc_en = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h0123);
        chk("single_idx", 32'(out_idx), 32'd0);
        chk("single_count", 32'(count), 32'd1);
        chk("single_proto", 32'(proto_err), 32'd0);
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        chk("single_drained", 32'(empty), 32'd1);

        // Fill to DEPTH, fifth result dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            grp(16'h1000 + 16'(i), i < 4);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_overflow", 32'(overflow), 32'd1);
        chk("fill_head_idx", 32'(out_idx), 32'd0);
        chk("fill_head_data", 32'(out_data), 32'h1000);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_count", 32'(count), 32'd4);

        // Full with push and pop on the same edge
        acc_sel = 1'b1;
        cyc();
        acc_sel   = 1'b0;
        acc_en    = 1'b1;
        acc_data  = 16'h2004;
        out_ready = 1'b1;
        push_exp(16'h2004);
        cyc();
        acc_en    = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_overflow", 32'(overflow), 32'd0);
        chk("pp_head_idx", 32'(out_idx), 32'd1);
        chk("pp_head_data", 32'(out_data), 32'h1001);
        out_ready = 1'b1;
        repeat (5) cyc();
        out_ready = 1'b0;
        chk("pp_drained", 32'(empty), 32'd1);
        chk("pp_ready_on_empty_count", 32'(count), 32'd0);

        // Argmax over a full frame, then index wraps to 0
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            grp(16'(vals[i]), 1'b1);
            if (i == 8) chk("amax_no_early_pulse", 32'(best_valid), 32'd0);
        end
        chk("amax_pulse", 32'(best_valid), 32'd1);
        chk("amax_idx", 32'(best_idx), 32'd2);
        cyc();
        chk("amax_pulse_end", 32'(best_valid), 32'd0);
        chk("amax_idx_hold", 32'(best_idx), 32'd2);
        grp(16'h0042, 1'b1);
        cyc();
        cyc();
        out_ready = 1'b0;
        chk("amax_drained", 32'(empty), 32'd1);

        // Arm/protocol tracking
        do_reset();
        out_ready = 1'b1;
        acc_sel = 1'b1;
        cyc();
        acc_sel  = 1'b0;
        acc_en   = 1'b1;
        acc_data = 16'h0011;
        push_exp(16'h0011);
        cyc();
        chk("proto_armed_ok", 32'(proto_err), 32'd0);
        acc_data = 16'h0012;
        push_exp(16'h0012);
        cyc();
        acc_en = 1'b0;
        chk("proto_set", 32'(proto_err), 32'd1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        chk("proto_clr", 32'(proto_err), 32'd0);
        acc_sel  = 1'b1;
        acc_en   = 1'b1;
        acc_data = 16'h0013;
        push_exp(16'h0013);
        cyc();
        acc_sel = 1'b0;
        acc_en  = 1'b0;
        chk("proto_sel_en_same", 32'(proto_err), 32'd0);
        acc_en   = 1'b1;
        clr_err  = 1'b1;
        acc_data = 16'h0014;
        push_exp(16'h0014);
        cyc();
        acc_en  = 1'b0;
        clr_err = 1'b0;
        chk("proto_set_beats_clr", 32'(proto_err), 32'd1);
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
        cyc();
        chk("proto_clr2", 32'(proto_err), 32'd0);
        out_ready = 1'b0;
        chk("proto_drained", 32'(empty), 32'd1);

        // Asynchronous reset mid-frame
        do_reset();
        grp(16'h0031, 1'b1);
        grp(16'h0032, 1'b1);
        grp(16'h0033, 1'b1);
        chk("arst_pre_count", 32'(count), 32'd3);
        #3;
        reset = 1'b0;
        exp_q.delete();
        nxt_idx = 4'd0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        grp(16'h0041, 1'b1);
        chk("arst_new_idx", 32'(out_idx), 32'd0);
        chk("arst_new_data", 32'(out_data), 32'h0041);
        out_ready = 1'b1;
        cyc();
        cyc();
        out_ready = 1'b0;
        chk("arst_drained", 32'(empty), 32'd1);

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
